// File: rtl/serial_word_comp.sv
// Serial word complementer: LSB-first WIDTH-bit words are passed, ones'/two's
// complemented or incremented bit by bit, with one-cycle registered latency.
module serial_word_comp #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_bit,
    input  logic       in_first,
    input  logic [1:0] mode,
    output logic       out_valid,
    output logic       out_bit,
    output logic       out_first,
    output logic       out_last,
    output logic       out_flag,
    output logic       busy,
    output logic       err
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [1:0] MODE_PASS = 2'b00;
    localparam logic [1:0] MODE_ONES = 2'b01;
    localparam logic [1:0] MODE_TWOS = 2'b10;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic             seen_one_q, seen_one_d;
    logic             carry_q, carry_d;
    logic             out_valid_q, out_valid_d;
    logic             out_bit_q, out_bit_d;
    logic             out_first_q, out_first_d;
    logic             out_last_q, out_last_d;
    logic             out_flag_q, out_flag_d;
    logic             err_q, err_d;

    logic             start, process, is_last, x_bit, flag_bit;
    logic [1:0]       eff_mode;
    logic [CNT_W-1:0] eff_cnt;
    logic             eff_seen, eff_carry;

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path leaves a latch.
        start     = in_valid & in_first;
        process   = start | (in_valid & (state_q == BUSY));
        // A word start (including an abort-restart) reinitialises the per-word state.
        eff_mode  = start ? mode  : mode_q;
        eff_cnt   = start ? '0    : cnt_q;
        eff_seen  = start ? 1'b0  : seen_one_q;
        eff_carry = start ? 1'b1  : carry_q;
        is_last   = (eff_cnt == LAST_CNT);

        case (eff_mode)
            MODE_PASS: x_bit = in_bit;
            MODE_ONES: x_bit = ~in_bit;
            MODE_TWOS: x_bit = eff_seen ? ~in_bit : in_bit;
            default:   x_bit = in_bit ^ eff_carry;
        endcase

        case (eff_mode)
            MODE_TWOS: flag_bit = is_last & in_bit & ~eff_seen;
            2'b11:     flag_bit = is_last & in_bit & eff_carry;
            default:   flag_bit = 1'b0;
        endcase

        state_d     = state_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        seen_one_d  = seen_one_q;
        carry_d     = carry_q;
        out_valid_d = 1'b0;
        out_bit_d   = out_bit_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        out_flag_d  = out_flag_q;
        err_d       = in_valid & (((state_q == IDLE) & ~in_first) |
                                  ((state_q == BUSY) & in_first));

        if (process) begin
            state_d     = is_last ? IDLE : BUSY;
            cnt_d       = is_last ? '0 : eff_cnt + CNT_W'(1);
            mode_d      = eff_mode;
            seen_one_d  = eff_seen | in_bit;
            carry_d     = in_bit & eff_carry;
            out_valid_d = 1'b1;
            out_bit_d   = x_bit;
            out_first_d = (eff_cnt == '0);
            out_last_d  = is_last;
            out_flag_d  = flag_bit;
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mode_q      <= MODE_PASS;
            seen_one_q  <= 1'b0;
            carry_q     <= 1'b1;
            out_valid_q <= 1'b0;
            out_bit_q   <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_flag_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            seen_one_q  <= seen_one_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            out_bit_q   <= out_bit_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            out_flag_q  <= out_flag_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign out_flag  = out_flag_q;
    assign busy      = (state_q == BUSY);
    assign err       = err_q;

endmodule
